kalman_ctrl: RTL and testbench

Sequencer that sits between the centroid detector and the `kalman` tracking datapath. It buffers one pending measurement, issues it to the filter with the filter's valid/ready handshake, and captures the filtered estimate when the filter returns to idle. It performs one filter step per frame: a fresh measurement when the frame produced one, otherwise a coast step that re-submits the last accepted measurement, up to a bounded count. It also flags lost tracks, dropped measurements and a hung filter.

---
 rtl/kalman_ctrl_if.sv | 26 ++
 rtl/kalman_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_kalman_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/kalman_ctrl_if.sv
// Handshake bundle between kalman_ctrl and the kalman filter datapath.
//   kf_z_x/kf_z_y   : measurement presented to the filter
//   kf_valid        : step request, held until the filter reports ready
//   kf_ready        : filter idle
//   kf_z_x_new/_y_new : filtered estimate from the filter
// master = sequencer side, slave = filter side.
interface kalman_ctrl_if #(
  parameter int unsigned DISP_WIDTH = 11
) ();
  logic [DISP_WIDTH-1:0] kf_z_x;
  logic [DISP_WIDTH-1:0] kf_z_y;
  logic                  kf_valid;
  logic                  kf_ready;
  logic [DISP_WIDTH-1:0] kf_z_x_new;
  logic [DISP_WIDTH-1:0] kf_z_y_new;

  modport master (
    output kf_z_x, kf_z_y, kf_valid,
    input  kf_ready, kf_z_x_new, kf_z_y_new
  );

  modport slave (
    input  kf_z_x, kf_z_y, kf_valid,
    output kf_ready, kf_z_x_new, kf_z_y_new
  );
endinterface

// File: rtl/kalman_ctrl.sv
// Sequencer between the centroid detector and the kalman filter.
// Buffers one pending job (fresh measurement or coast re-submission), runs
// one filter step through the kf handshake, captures the estimate, and
// flags lost tracks, overwritten measurements and a hung filter.
// Ports:
//   clk, areset            : clock, async active-high reset
//   meas_x/meas_y/meas_valid : detector centroid strobe
//   frame_tick             : end-of-frame strobe
//   kf                     : filter handshake (master side)
//   est_x/est_y/est_valid/est_coast : captured estimate and its step type
//   track_lost, drop_cnt, kf_err    : status
module kalman_ctrl #(
  parameter int unsigned DISP_WIDTH  = 11,
  parameter int unsigned MAX_COAST   = 4,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [DISP_WIDTH-1:0] meas_x,
  input  logic [DISP_WIDTH-1:0] meas_y,
  input  logic                  meas_valid,
  input  logic                  frame_tick,
  kalman_ctrl_if.master         kf,
  output logic [DISP_WIDTH-1:0] est_x,
  output logic [DISP_WIDTH-1:0] est_y,
  output logic                  est_valid,
  output logic                  est_coast,
  output logic                  track_lost,
  output logic [7:0]            drop_cnt,
  output logic                  kf_err
);

  localparam int unsigned WDOG_W     = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [3:0]  COAST_LIM  = 4'(MAX_COAST);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_CAPTURE
  } state_t;

  state_t state_q, state_d;

  logic                  pend_q, pend_coast_q;
  logic [DISP_WIDTH-1:0] pend_x_q, pend_y_q;
  logic [DISP_WIDTH-1:0] last_x_q, last_y_q;
  logic                  have_ref_q, seen_q;
  logic [3:0]            coast_cnt_q;
  logic [WDOG_W-1:0]     wdog_q;
  logic                  job_coast_q;

  logic issue, capture, abort, kf_valid_d, in_wait_d;
  logic wdog_hit;
  logic empty_tick, coast_req, lost_req, drop;

  assign wdog_hit = (wdog_q == WDOG_LAST);

  // Frame bookkeeping: a measurement in the tick cycle counts for the ending frame.
  assign empty_tick = frame_tick && !meas_valid && !seen_q && have_ref_q;
  assign coast_req  = empty_tick && (coast_cnt_q < COAST_LIM);
  assign lost_req   = empty_tick && !(coast_cnt_q < COAST_LIM);
  // A pending measurement issued this very cycle is not lost.
  assign drop       = meas_valid && pend_q && !pend_coast_q && !issue;

  // State register
  always_ff @(posedge clk or posedge areset) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and step control
  always_comb begin
    state_d    = state_q;
    issue      = 1'b0;
    capture    = 1'b0;
    abort      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          state_d = ST_ISSUE;
          issue   = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (kf.kf_ready) state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (wdog_hit) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (!kf.kf_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (wdog_hit) begin
          abort   = 1'b1;
          state_d = ST_IDLE;
        end else if (kf.kf_ready) begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    kf_valid_d = (state_d == ST_ISSUE);
    in_wait_d  = (state_d == ST_WAIT_BUSY) || (state_d == ST_WAIT_DONE);
  end

  // Job buffer, frame tracking and status
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pend_q       <= 1'b0;
      pend_coast_q <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      last_x_q     <= '0;
      last_y_q     <= '0;
      have_ref_q   <= 1'b0;
      seen_q       <= 1'b0;
      coast_cnt_q  <= '0;
      track_lost   <= 1'b1;
      drop_cnt     <= '0;
    end else begin
      if (issue) pend_q <= 1'b0;

      if (meas_valid) begin
        pend_q       <= 1'b1;
        pend_coast_q <= 1'b0;
        pend_x_q     <= meas_x;
        pend_y_q     <= meas_y;
        last_x_q     <= meas_x;
        last_y_q     <= meas_y;
        have_ref_q   <= 1'b1;
        coast_cnt_q  <= '0;
        track_lost   <= 1'b0;
      end else if (coast_req) begin
        pend_q       <= 1'b1;
        pend_coast_q <= 1'b1;
        pend_x_q     <= last_x_q;
        pend_y_q     <= last_y_q;
        coast_cnt_q  <= coast_cnt_q + 4'd1;
      end else if (lost_req) begin
        track_lost   <= 1'b1;
      end

      if (frame_tick)      seen_q <= 1'b0;
      else if (meas_valid) seen_q <= 1'b1;

      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Filter handshake, watchdog and estimate capture
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      kf.kf_z_x   <= '0;
      kf.kf_z_y   <= '0;
      kf.kf_valid <= 1'b0;
      job_coast_q <= 1'b0;
      wdog_q      <= '0;
      est_x       <= '0;
      est_y       <= '0;
      est_valid   <= 1'b0;
      est_coast   <= 1'b0;
      kf_err      <= 1'b0;
    end else begin
      kf.kf_valid <= kf_valid_d;
      if (issue) begin
        kf.kf_z_x   <= pend_x_q;
        kf.kf_z_y   <= pend_y_q;
        job_coast_q <= pend_coast_q;
      end

      // Counts consecutive busy-wait cycles of the current step.
      if (in_wait_d) wdog_q <= wdog_q + 1'b1;
      else           wdog_q <= '0;

      est_valid <= capture;
      if (capture) begin
        est_x     <= kf.kf_z_x_new;
        est_y     <= kf.kf_z_y_new;
        est_coast <= job_coast_q;
      end

      if (abort) kf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_kalman_ctrl.sv
// Directed self-checking bench for kalman_ctrl with an echoing filter model
// (3 busy cycles per step, optionally stuck busy).
module tb_kalman_ctrl;

  localparam int unsigned DW = 11;

  logic          clk = 1'b0;
  logic          areset;
  logic [DW-1:0] meas_x = '0;
  logic [DW-1:0] meas_y = '0;
  logic          meas_valid = 1'b0;
  logic          frame_tick = 1'b0;
  logic [DW-1:0] est_x, est_y;
  logic          est_valid, est_coast, track_lost, kf_err;
  logic [7:0]    drop_cnt;

  logic          stuck = 1'b0;
  logic [1:0]    busy_cnt;

  int n_pass  = 0;
  int n_total = 0;

  kalman_ctrl_if #(.DISP_WIDTH(DW)) kif ();

  kalman_ctrl #(
    .DISP_WIDTH (DW),
    .MAX_COAST  (4),
    .WDOG_CYCLES(64)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .meas_x     (meas_x),
    .meas_y     (meas_y),
    .meas_valid (meas_valid),
    .frame_tick (frame_tick),
    .kf         (kif),
    .est_x      (est_x),
    .est_y      (est_y),
    .est_valid  (est_valid),
    .est_coast  (est_coast),
    .track_lost (track_lost),
    .drop_cnt   (drop_cnt),
    .kf_err     (kf_err)
  );

  always #5 clk = ~clk;

  // Filter model: accepts on valid&ready, busy 3 cycles, echoes the input.
  always @(posedge clk or posedge areset) begin
    if (areset) begin
      kif.kf_ready   <= 1'b1;
      kif.kf_z_x_new <= '0;
      kif.kf_z_y_new <= '0;
      busy_cnt       <= 2'd0;
    end else if (busy_cnt != 2'd0) begin
      busy_cnt <= busy_cnt - 2'd1;
      if (busy_cnt == 2'd1 && !stuck) kif.kf_ready <= 1'b1;
    end else if (kif.kf_valid && kif.kf_ready) begin
      kif.kf_ready   <= 1'b0;
      busy_cnt       <= 2'd3;
      kif.kf_z_x_new <= kif.kf_z_x;
      kif.kf_z_y_new <= kif.kf_z_y;
    end
  end

  // Event counters: filter requests issued and estimates delivered.
  int unsigned step_cnt = 0;
  int unsigned est_cnt  = 0;
  logic        kv_prev  = 1'b0;
  always @(negedge clk) begin
    kv_prev <= kif.kf_valid;
    if (kif.kf_valid && !kv_prev) step_cnt <= step_cnt + 1;
    if (est_valid) est_cnt <= est_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic meas(input int x, input int y);
    meas_x = DW'(x); meas_y = DW'(y); meas_valid = 1'b1;
    @(negedge clk);
    meas_valid = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic meas_tick(input int x, input int y);
    meas_x = DW'(x); meas_y = DW'(y); meas_valid = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    meas_valid = 1'b0; frame_tick = 1'b0;
  endtask

  task automatic check_est(input string tag, input int x, input int y, input logic coast);
    check({tag, "_valid"}, 32'(est_valid), 32'd1);
    check({tag, "_x"},     32'(est_x),     32'(x));
    check({tag, "_y"},     32'(est_y),     32'(y));
    check({tag, "_coast"}, 32'(est_coast), 32'(coast));
  endtask

  initial begin
    int unsigned base_steps, base_est;
    int n;
    areset = 1'b1;
    step(3);
    // Reset values
    check("rst_track_lost", 32'(track_lost),   32'd1);
    check("rst_kf_valid",   32'(kif.kf_valid), 32'd0);
    check("rst_est_valid",  32'(est_valid),    32'd0);
    check("rst_drop_cnt",   32'(drop_cnt),     32'd0);
    check("rst_kf_err",     32'(kf_err),       32'd0);
    areset = 1'b0;
    step(2);

    // Ticks with no reference produce nothing
    base_steps = step_cnt;
    tick(); step(3); tick(); step(10);
    check("noref_steps", step_cnt - base_steps, 32'd0);
    check("noref_lost",  32'(track_lost), 32'd1);

    // Single measurement, exact latency
    meas(100, 200);
    check("single_kv_early", 32'(kif.kf_valid), 32'd0);
    step(1);
    check("single_kv_rise", 32'(kif.kf_valid), 32'd1);
    check("single_kz_x",    32'(kif.kf_z_x),   32'd100);
    check("single_kz_y",    32'(kif.kf_z_y),   32'd200);
    step(1);
    check("single_kv_fall", 32'(kif.kf_valid), 32'd0);
    check("single_kz_hold", 32'(kif.kf_z_x),   32'd100);
    step(4);
    check("single_ev_early", 32'(est_valid), 32'd0);
    step(1);
    check_est("single", 100, 200, 1'b0);
    check("single_lost", 32'(track_lost), 32'd0);
    step(1);
    check("single_ev_pulse", 32'(est_valid), 32'd0);
    step(4); tick(); step(4);

    // Overwrite while busy
    meas(10, 10);
    step(2);
    meas(20, 20);
    meas(30, 30);
    check("ovw_drop_cnt", 32'(drop_cnt), 32'd1);
    step(3);
    check_est("ovw_first", 10, 10, 1'b0);
    step(1);
    check("ovw_kv_second", 32'(kif.kf_valid), 32'd1);
    check("ovw_kz_x",      32'(kif.kf_z_x),   32'd30);
    check("ovw_kz_y",      32'(kif.kf_z_y),   32'd30);
    step(6);
    check_est("ovw_second", 30, 30, 1'b0);
    check("ovw_drop_keep", 32'(drop_cnt), 32'd1);
    step(4);
    base_steps = step_cnt;
    tick(); step(10);
    check("seen_tick_steps", step_cnt - base_steps, 32'd0);

    // Coasting up to MAX_COAST, then lost
    meas(50, 60); step(10); tick(); step(10);
    base_steps = step_cnt;
    for (int k = 1; k <= 4; k++) begin
      tick();
      step(7);
      check_est($sformatf("coast%0d", k), 50, 60, 1'b1);
      check($sformatf("coast%0d_lost", k), 32'(track_lost), 32'd0);
      step(7);
    end
    tick();
    check("coast_lost_set", 32'(track_lost), 32'd1);
    step(10);
    check("coast_steps", step_cnt - base_steps, 32'd4);
    meas(70, 80);
    check("coast_lost_clr", 32'(track_lost), 32'd0);
    step(7);
    check_est("coast_recover", 70, 80, 1'b0);
    step(5); tick(); step(10);

    // Measurement and tick in the same cycle
    base_steps = step_cnt;
    meas_tick(90, 91);
    step(7);
    check_est("simul", 90, 91, 1'b0);
    step(5);
    check("simul_steps", step_cnt - base_steps, 32'd1);
    tick();
    step(7);
    check_est("simul_coast", 90, 91, 1'b1);
    step(5);
    check("simul_steps2", step_cnt - base_steps, 32'd2);

    // Watchdog on a hung filter
    base_est = est_cnt;
    stuck = 1'b1;
    meas(5, 6);
    step(1);
    check("wdog_kv", 32'(kif.kf_valid), 32'd1);
    step(58);
    check("wdog_err_early", 32'(kf_err), 32'd0);
    n = 0;
    while (!kf_err && n < 40) begin
      step(1);
      n++;
    end
    check("wdog_err_set", 32'(kf_err), 32'd1);
    check("wdog_kv_idle", 32'(kif.kf_valid), 32'd0);
    step(2);
    meas(7, 8);
    step(1);
    check("wdog_reissue_kv", 32'(kif.kf_valid), 32'd1);
    check("wdog_reissue_kz", 32'(kif.kf_z_x),   32'd7);

    // Reset mid-step
    areset = 1'b1;
    step(1);
    check("mrst_kf_valid",   32'(kif.kf_valid), 32'd0);
    check("mrst_kz_x",       32'(kif.kf_z_x),   32'd0);
    check("mrst_est_x",      32'(est_x),        32'd0);
    check("mrst_est_y",      32'(est_y),        32'd0);
    check("mrst_est_coast",  32'(est_coast),    32'd0);
    check("mrst_track_lost", 32'(track_lost),   32'd1);
    check("mrst_drop_cnt",   32'(drop_cnt),     32'd0);
    check("mrst_kf_err",     32'(kf_err),       32'd0);
    stuck  = 1'b0;
    areset = 1'b0;
    step(12);
    check("wdog_no_est", est_cnt - base_est, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
